pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Sequencer for the PC register/mux datapath (EN, mux select, external target).
//  - Boots the PC to a reset vector.
//  - Issues instruction fetches to imem with a req/ack handshake; advances PC by +4 on each accepted ack.
//  - Arbitrates redirect requests (trap/jump/branch); stalls on request; flags a hung imem.
// PARAMETERS
//  RESET_VEC    32'h0000_0000  PC loaded in BOOT
//  TRAP_VEC     32'h0000_0100  PC loaded on trap (PC_TRAP_EN only)
//  ACK_TIMEOUT  16             WAIT cycles without ack before ERR (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  pc           in   32  current PC register value
//  stall        in   1   1 = do not issue a new fetch
//  br_valid     in   1   branch redirect request (1-cycle pulse)
//  br_target    in   32  branch target
//  jmp_valid    in   1   jump redirect request (1-cycle pulse)
//  jmp_target   in   32  jump target
//  trap_valid   in   1   trap redirect request (PC_TRAP_EN only)
//  imem_req     out  1   fetch request; imem_addr = pc while high
//  imem_addr    out  32  fetch address
//  imem_ack     in   1   fetch done; counts only while imem_req=1
//  pc_en        out  1   PC register enable (combinational)
//  pc_mode      out  1   PC mux select: 0 = pc+4, 1 = pc_target (combinational)
//  pc_target    out  32  redirect/boot target (combinational, 0 when unused)
//  fetch_valid  out  1   registered; 1 for 1 cycle after a non-squashed ack
//  fetch_pc     out  32  registered; address of that fetch
//  timeout_err  out  1   sticky error flag
// BEHAVIOUR
//  - Reset: state=BOOT, pending redirect cleared, timeout counter=0.
//    All outputs 0 during rst, including after rst asserts mid-request; imem_req drops the same cycle.
//  - States: BOOT, ISSUE, WAIT, ERR.
//  - BOOT, 1 cycle:
//    - pc_en=1, pc_mode=1, pc_target=RESET_VEC.
//    - -> ISSUE.
//  - Redirect winner: trap > jmp > br.
//    - A redirect arriving while a request is outstanding is latched as pending.
//    - A later request replaces the pending one only if its priority is >= the pending priority.
//  - ISSUE, redirect (pending or incoming):
//    - pc_en=1, pc_mode=1, pc_target=winner.
//    - imem_req=0; pending cleared; stay in ISSUE.
//    - Applies even while stall=1.
//  - ISSUE, no redirect, stall=1: imem_req=0, pc_en=0; stay in ISSUE.
//  - ISSUE, no redirect, stall=0: imem_req=1.
//    - ack in the same cycle: pc_en=1, pc_mode=0; stay in ISSUE.
//    - no ack: -> WAIT.
//  - WAIT: imem_req=1; stall ignored; the counter increments each cycle without ack.
//    - On ack with no redirect (pending or incoming): pc_en=1, pc_mode=0, next-cycle fetch_valid=1 and fetch_pc=pc.
//    - On ack with a redirect: pc_en=1, pc_mode=1, pc_target=winner; the fetch is squashed (fetch_valid stays 0); pending cleared.
//    - Either way: counter=0, -> ISSUE.
//    - Counter reaching ACK_TIMEOUT without ack: -> ERR.
//  - ERR: timeout_err=1, imem_req=0, pc_en=0. Only rst exits.
//  - Counter width $clog2(ACK_TIMEOUT+1).
//  - The same-cycle ack in ISSUE produces fetch_valid like WAIT.
// CONFIGURATION
//  PC_TRAP_EN defined: trap_valid port present; top redirect priority; target TRAP_VEC.
//  PC_TRAP_EN undefined: trap_valid port and TRAP_VEC logic absent; priority jmp > br.
// TESTING
//  1. rst 2 cycles, release:
//     - cycle 1: pc_en=1, pc_mode=1, pc_target=0.
//     - cycle 2: imem_req=1, imem_addr=0.
//  2. imem_ack held 1, stall=0:
//     - pc_en=1, pc_mode=0 every cycle.
//     - fetch_pc sequence 0x0, 0x4, 0x8, each with fetch_valid=1.
//  3. br_valid with 0x40 in WAIT, ack 3 cycles later:
//     - at ack: pc_mode=1, pc_target=0x40; next cycle fetch_valid=0.
//     - next fetch_pc=0x40.
//  4. jmp_valid 0x80 + br_valid 0x40 in the same ISSUE cycle:
//     - pc_target=0x80, imem_req=0 that cycle.
//  5. stall=1 for 5 ISSUE cycles: imem_req=0, pc_en=0 throughout; stall=0 -> imem_req=1 the next cycle.
//  6. imem_ack never asserted: timeout_err=1 after 16 WAIT cycles; imem_req=0; held until rst.
//     - PC_TRAP_EN variant: trap_valid + jmp_valid together give pc_target=0x100.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: boot, imem req/ack fetch, trap>jmp>br redirect arbitration, imem hang detect (trap path built with PC_TRAP_EN).
// Latency: pc_en/pc_mode/pc_target/imem_req combinational; fetch_valid/fetch_pc one cycle after an accepted ack.
// Backpressure: stall holds ISSUE without requesting; an outstanding request waits for ack or times out into ERR.
module pc_fetch_ctrl #(
`ifdef PC_TRAP_EN
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
`endif
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
`ifdef PC_TRAP_EN
    input  logic        trap_valid,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        pc_en,
    output logic        pc_mode,
    output logic [31:0] pc_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_BR   = 2'd1;
    localparam logic [1:0] PRIO_JMP  = 2'd2;
`ifdef PC_TRAP_EN
    localparam logic [1:0] PRIO_TRAP = 2'd3;
`endif

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_ISSUE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         pend_prio, pend_prio_nxt;
    logic [31:0]        pend_tgt, pend_tgt_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               fv_q, fv_nxt;
    logic [31:0]        fpc_q;

    logic [1:0]         in_prio, win_prio;
    logic [31:0]        in_tgt, win_tgt;
    logic               has_redir;

    logic               req_c, en_c, mode_c;
    logic [31:0]        tgt_c;

    // Highest-priority incoming request; later pulses of equal or higher
    // priority override whatever is already pending.
    always_comb begin
        in_prio = PRIO_NONE;
        in_tgt  = '0;
        if (br_valid) begin
            in_prio = PRIO_BR;
            in_tgt  = br_target;
        end
        if (jmp_valid) begin
            in_prio = PRIO_JMP;
            in_tgt  = jmp_target;
        end
`ifdef PC_TRAP_EN
        if (trap_valid) begin
            in_prio = PRIO_TRAP;
            in_tgt  = TRAP_VEC;
        end
`endif
        if (in_prio != PRIO_NONE && in_prio >= pend_prio) begin
            win_prio = in_prio;
            win_tgt  = in_tgt;
        end else begin
            win_prio = pend_prio;
            win_tgt  = pend_tgt;
        end
    end

    assign has_redir = (win_prio != PRIO_NONE);

    always_comb begin
        state_nxt     = state;
        pend_prio_nxt = pend_prio;
        pend_tgt_nxt  = pend_tgt;
        cnt_nxt       = cnt;
        fv_nxt        = 1'b0;
        req_c         = 1'b0;
        en_c          = 1'b0;
        mode_c        = 1'b0;
        tgt_c         = '0;

        case (state)
            ST_BOOT: begin
                en_c          = 1'b1;
                mode_c        = 1'b1;
                tgt_c         = RESET_VEC;
                pend_prio_nxt = win_prio;
                pend_tgt_nxt  = win_tgt;
                state_nxt     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (has_redir) begin
                    en_c          = 1'b1;
                    mode_c        = 1'b1;
                    tgt_c         = win_tgt;
                    pend_prio_nxt = PRIO_NONE;
                    pend_tgt_nxt  = '0;
                end else if (!stall) begin
                    req_c = 1'b1;
                    if (imem_ack) begin
                        en_c   = 1'b1;
                        fv_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    en_c      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_ISSUE;
                    if (has_redir) begin
                        mode_c        = 1'b1;
                        tgt_c         = win_tgt;
                        pend_prio_nxt = PRIO_NONE;
                        pend_tgt_nxt  = '0;
                    end else begin
                        fv_nxt = 1'b1;
                    end
                end else begin
                    pend_prio_nxt = win_prio;
                    pend_tgt_nxt  = win_tgt;
                    cnt_nxt       = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BOOT;
            pend_prio <= PRIO_NONE;
            pend_tgt  <= '0;
            cnt       <= '0;
            fv_q      <= 1'b0;
            fpc_q     <= '0;
        end else begin
            state     <= state_nxt;
            pend_prio <= pend_prio_nxt;
            pend_tgt  <= pend_tgt_nxt;
            cnt       <= cnt_nxt;
            fv_q      <= fv_nxt;
            if (fv_nxt) begin
                fpc_q <= pc;
            end
        end
    end

    // Every output is forced low while rst is high, so a request in flight drops immediately.
    assign imem_req    = req_c & ~rst;
    assign imem_addr   = (req_c && !rst) ? pc : '0;
    assign pc_en       = en_c & ~rst;
    assign pc_mode     = mode_c & ~rst;
    assign pc_target   = rst ? '0 : tgt_c;
    assign fetch_valid = fv_q & ~rst;
    assign fetch_pc    = rst ? '0 : fpc_q;
    assign timeout_err = (state == ST_ERR) & ~rst;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, timeout/trap sequences, then random stimulus vs. a reference model.
module tb_pc_fetch_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid, jmp_valid, imem_ack;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc = 32'h1234_5678;
`ifdef PC_TRAP_EN
    logic        trap_valid;
`endif
    logic        imem_req, pc_en, pc_mode, fetch_valid, timeout_err;
    logic [31:0] imem_addr, pc_target, fetch_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // PC register the controller sequences.
    always @(posedge clk) begin
        if (pc_en) pc <= pc_mode ? pc_target : pc + 32'd4;
    end

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .br_valid(br_valid), .br_target(br_target),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
`ifdef PC_TRAP_EN
        .trap_valid(trap_valid),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .pc_en(pc_en), .pc_mode(pc_mode), .pc_target(pc_target),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        rst, stall, bv;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic        en, mode;
        logic [31:0] tgt;
        logic        fv;
        logic [31:0] fpc;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, s, bv, input logic [31:0] bt, input logic jv,
                       input logic [31:0] jt, input logic a, input logic q, input logic [31:0] ad,
                       input logic e, m, input logic [31:0] t, input logic f,
                       input logic [31:0] fp, input logic er);
        vec_t v;
        v.rst = r; v.stall = s; v.bv = bv; v.bt = bt; v.jv = jv; v.jt = jt; v.ack = a;
        v.req = q; v.addr = ad; v.en = e; v.mode = m; v.tgt = t; v.fv = f; v.fpc = fp; v.err = er;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, s, bv, input logic [31:0] bt, input logic jv,
                         input logic [31:0] jt, input logic a);
        @(negedge clk);
        rst = r; stall = s; br_valid = bv; br_target = bt;
        jmp_valid = jv; jmp_target = jt; imem_ack = a;
`ifdef PC_TRAP_EN
        trap_valid = 1'b0;
`endif
        #1;
    endtask

    // Reference model state, kept at the level of "what the fetch unit is doing".
    logic        m_boot, m_busy, m_dead, m_fv;
    int          m_waited, m_pp, m_wp;
    logic [31:0] m_pt, m_fpc, m_wt;
    logic        e_req, e_en, e_mode, e_fv, e_err, nfv;
    logic [31:0] e_tgt, e_fpc;
    logic        r_r, r_s, r_bv, r_jv, r_a;
    logic [31:0] r_bt, r_jt;
    int          ack_pct, ip;
    logic [31:0] it;

    initial begin
        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; imem_ack = 1'b0;
        br_target = '0; jmp_target = '0;
`ifdef PC_TRAP_EN
        trap_valid = 1'b0;
`endif

        // rst stall bv bt jv jt ack | req addr en mode tgt fv fpc err
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,1,1,0,0,0,0);                 // boot
        add(0,0,0,0,0,0,1, 1,32'h0,1,0,0,0,0,0);             // back-to-back acks
        add(0,0,0,0,0,0,1, 1,32'h4,1,0,0,1,32'h0,0);
        add(0,0,0,0,0,0,1, 1,32'h8,1,0,0,1,32'h4,0);
        add(0,0,0,0,0,0,0, 1,32'hc,0,0,0,1,32'h8,0);
        add(0,0,1,32'h40,0,0,0, 1,32'hc,0,0,0,0,0,0);        // br pending in WAIT
        add(0,0,0,0,0,0,0, 1,32'hc,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,32'hc,0,0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,32'hc,1,1,32'h40,0,0,0);        // squashed ack
        add(0,0,0,0,0,0,0, 1,32'h40,0,0,0,0,0,0);
        add(0,0,0,0,0,0,1, 1,32'h40,1,0,0,0,0,0);
        add(0,0,1,32'h40,1,32'h80,0, 0,0,1,1,32'h80,1,32'h40,0); // jmp beats br
        for (int i = 0; i < 5; i++) add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,32'h80,0,0,0,0,0,0);
        add(0,1,0,0,0,0,1, 1,32'h80,1,0,0,0,0,0);            // stall ignored in WAIT
        add(0,1,1,32'h200,0,0,0, 0,0,1,1,32'h200,1,32'h80,0); // redirect during stall
        add(0,0,0,0,0,0,1, 1,32'h200,1,0,0,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,1,32'h200,0);
        add(0,0,0,0,0,0,0, 1,32'h204,0,0,0,0,0,0);
        add(0,0,0,0,1,32'h300,0, 1,32'h204,0,0,0,0,0,0);     // pending jmp
        add(0,0,1,32'h400,0,0,0, 1,32'h204,0,0,0,0,0,0);     // lower br ignored
        add(0,0,0,0,0,0,1, 1,32'h204,1,1,32'h300,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,32'h300,0,0,0,0,0,0);
        add(0,0,1,32'h500,0,0,0, 1,32'h300,0,0,0,0,0,0);
        add(0,0,1,32'h600,0,0,0, 1,32'h300,0,0,0,0,0,0);     // equal prio replaces
        add(0,0,0,0,0,0,1, 1,32'h300,1,1,32'h600,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0, 1,32'h600,0,0,0,0,0,0);
        add(0,0,1,32'h800,0,0,0, 1,32'h600,0,0,0,0,0,0);
        add(0,0,0,0,1,32'h700,1, 1,32'h600,1,1,32'h700,0,0,0); // incoming jmp beats pending br
        add(0,0,0,0,0,0,0, 1,32'h700,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);                 // rst mid-request
        add(0,0,0,0,0,0,0, 0,0,1,1,0,0,0,0);
        add(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].bv, tbl[i].bt, tbl[i].jv, tbl[i].jt, tbl[i].ack);
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("row%0d pc_en", i), 32'(pc_en), 32'(tbl[i].en));
            chk($sformatf("row%0d pc_mode", i), 32'(pc_mode), 32'(tbl[i].mode));
            chk($sformatf("row%0d pc_target", i), pc_target, tbl[i].tgt);
            chk($sformatf("row%0d fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].fv));
            chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].err));
            if (tbl[i].req || tbl[i].rst)
                chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            if (tbl[i].fv || tbl[i].rst)
                chk($sformatf("row%0d fetch_pc", i), fetch_pc, tbl[i].fpc);
        end

        // Hung imem: request held through ISSUE plus 16 WAIT cycles, then sticky error.
        drive(1,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,0);
        for (int i = 0; i <= TMO; i++) begin
            drive(0,0,0,0,0,0,0);
            chk($sformatf("tmo%0d imem_req", i), 32'(imem_req), 32'd1);
            chk($sformatf("tmo%0d timeout_err", i), 32'(timeout_err), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0,0,1,32'h40,1,32'h80,1);
            chk($sformatf("err%0d timeout_err", i), 32'(timeout_err), 32'd1);
            chk($sformatf("err%0d imem_req", i), 32'(imem_req), 32'd0);
            chk($sformatf("err%0d pc_en", i), 32'(pc_en), 32'd0);
        end
        drive(1,0,0,0,0,0,0);
        chk("err_rst timeout_err", 32'(timeout_err), 32'd0);
        drive(1,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,0);
        chk("err_boot pc_en", 32'(pc_en), 32'd1);

`ifdef PC_TRAP_EN
        drive(0,1,0,0,1,32'h80,0);
        trap_valid = 1'b1;
        #1;
        chk("trap pc_target", pc_target, 32'h100);
        chk("trap pc_mode", 32'(pc_mode), 32'd1);
        chk("trap imem_req", 32'(imem_req), 32'd0);
`endif

        // Random phase: model starts from a fresh reset.
        drive(1,0,0,0,0,0,0);
        m_boot = 1'b1; m_busy = 1'b0; m_dead = 1'b0; m_fv = 1'b0;
        m_waited = 0; m_pp = 0; m_pt = '0; m_fpc = '0;
        ack_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(3))
                    0: ack_pct = 5;
                    1: ack_pct = 40;
                    default: ack_pct = 85;
                endcase
            end
            r_r  = ($urandom_range(99) == 0);
            r_s  = ($urandom_range(99) < 30);
            r_a  = ($urandom_range(99) < ack_pct);
            r_bv = ($urandom_range(99) < 12) && !m_boot;
            r_jv = ($urandom_range(99) < 10) && !m_boot;
            r_bt = $urandom & 32'hffff_fffc;
            r_jt = $urandom & 32'hffff_fffc;
            drive(r_r, r_s, r_bv, r_bt, r_jv, r_jt, r_a);

            e_req = 0; e_en = 0; e_mode = 0; e_tgt = '0; e_err = 0; nfv = 0;
            e_fv = m_fv; e_fpc = m_fpc;
            if (r_r) begin
                e_fv = 0; e_fpc = '0;
                m_boot = 1; m_busy = 0; m_dead = 0; m_waited = 0; m_pp = 0; m_pt = '0; m_fpc = '0;
            end else if (m_dead) begin
                e_err = 1;
            end else if (m_boot) begin
                e_en = 1; e_mode = 1; e_tgt = 32'h0;
                m_boot = 0;
            end else begin
                ip = r_jv ? 2 : (r_bv ? 1 : 0);
                it = r_jv ? r_jt : r_bt;
                if (ip > 0 && ip >= m_pp) begin m_wp = ip; m_wt = it; end
                else begin m_wp = m_pp; m_wt = m_pt; end
                if (!m_busy) begin
                    if (m_wp > 0) begin
                        e_en = 1; e_mode = 1; e_tgt = m_wt; m_pp = 0;
                    end else if (!r_s) begin
                        e_req = 1;
                        if (r_a) begin e_en = 1; nfv = 1; end
                        else begin m_busy = 1; m_waited = 0; end
                    end
                end else begin
                    e_req = 1;
                    if (r_a) begin
                        e_en = 1; m_busy = 0;
                        if (m_wp > 0) begin e_mode = 1; e_tgt = m_wt; m_pp = 0; end
                        else nfv = 1;
                    end else begin
                        m_pp = m_wp; m_pt = m_wt;
                        m_waited++;
                        if (m_waited == TMO) m_dead = 1;
                    end
                end
            end

            chk($sformatf("rnd%0d imem_req", c), 32'(imem_req), 32'(e_req));
            chk($sformatf("rnd%0d pc_en", c), 32'(pc_en), 32'(e_en));
            chk($sformatf("rnd%0d pc_mode", c), 32'(pc_mode), 32'(e_mode));
            chk($sformatf("rnd%0d pc_target", c), pc_target, e_tgt);
            chk($sformatf("rnd%0d fetch_valid", c), 32'(fetch_valid), 32'(e_fv));
            chk($sformatf("rnd%0d timeout_err", c), 32'(timeout_err), 32'(e_err));
            if (e_req || r_r) chk($sformatf("rnd%0d imem_addr", c), imem_addr, r_r ? 32'h0 : pc);
            if (e_fv || r_r)  chk($sformatf("rnd%0d fetch_pc", c), fetch_pc, e_fpc);

            if (!r_r) begin
                m_fv = nfv;
                if (nfv) m_fpc = pc;
            end else begin
                m_fv = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
